// File: rtl/ce_delay_pkg.sv
// ce_delay_pkg: shared definitions for the clock-enabled delay line.
//   - occ_width(): width of the occupancy counter, clog2(DEPTH+1)
//   - rec_width(): width of one stage record, laid out {parity, valid, data}
//   - REC_* offsets: bit positions of the record fields relative to WIDTH
//   - DEFAULT_RESET_BIT: bit replicated to form the default RESET_VAL
// Optional feature macro: CE_DELAY_PARITY_EN (per-stage parity bit).
package ce_delay_pkg;

   localparam bit DEFAULT_RESET_BIT = 1'b0;

   // Field offsets inside a stage record of a given data width W:
   // data = [W-1:0], valid = [W], parity = [W+1].
   localparam int unsigned REC_VALID_OFS  = 0;
   localparam int unsigned REC_PARITY_OFS = 1;

   function automatic int unsigned occ_width(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int unsigned rec_width(input int unsigned width);
      return width + 2;
   endfunction

endpackage

// File: rtl/ce_stage.sv
// ce_stage: one WIDTH-bit enable/flush register stage with a valid bit and,
// when CE_DELAY_PARITY_EN is defined, a parity bit travelling with the data.
// Ports:
//   clk_i      rising-edge clock
//   rst_ni     synchronous active-low reset
//   enable_i   1 = capture the inputs, 0 = hold
//   flush_i    1 = load RESET_VAL / invalid (wins over enable_i)
//   data_i     incoming data word
//   valid_i    qualifier of data_i (data moves regardless of valid)
//   parity_i   parity bit to store alongside data_i (ignored without the macro)
//   rec_o      registered record {parity, valid, data}; parity reads 0
//              when no parity storage is built
module ce_stage
   import ce_delay_pkg::*;
#(
   parameter int unsigned       WIDTH     = 8,
   parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
   input  logic                        clk_i,
   input  logic                        rst_ni,
   input  logic                        enable_i,
   input  logic                        flush_i,
   input  logic [WIDTH-1:0]            data_i,
   input  logic                        valid_i,
   input  logic                        parity_i,
   output logic [rec_width(WIDTH)-1:0] rec_o
);

   logic [WIDTH-1:0] data_q, data_d;
   logic             valid_q, valid_d;
   logic             parity_bit;

   // Priority below reset: flush > enable > hold.
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      if (flush_i) begin
         data_d  = RESET_VAL;
         valid_d = 1'b0;
      end else if (enable_i) begin
         data_d  = data_i;
         valid_d = valid_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         data_q  <= RESET_VAL;
         valid_q <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
      end
   end

`ifdef CE_DELAY_PARITY_EN
   logic parity_q, parity_d;

   always_comb begin
      parity_d = parity_q;
      if (flush_i) begin
         parity_d = ^RESET_VAL;
      end else if (enable_i) begin
         parity_d = parity_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         parity_q <= ^RESET_VAL;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity_bit = parity_q;
`else
   logic unused_parity_i;
   assign unused_parity_i = parity_i;
   assign parity_bit      = 1'b0;
`endif

   assign rec_o = {parity_bit, valid_q, data_q};

endmodule

// File: rtl/ce_delay_line.sv
// ce_delay_line: DEPTH cascaded clock-enabled stages with valid bits, flush,
// live occupancy count and optional per-stage parity (CE_DELAY_PARITY_EN).
// Ports:
//   clk, rst_n (sync, active-low), enable (shift all stages), flush
//   data_in / valid_in   word and qualifier entering stage 0
//   err_inject           invert the stored parity of the incoming word
//   data_out / valid_out contents of stage DEPTH-1
//   taps                 stage k at bits [k*WIDTH +: WIDTH]
//   occupancy            number of valid stages
//   parity_err           valid_out & parity mismatch on the output stage
// valid_in/valid_out are plain qualifiers: there is no back-pressure, a word
// is accepted on every edge with enable=1 and flush=0, valid or not.
module ce_delay_line
   import ce_delay_pkg::*;
#(
   parameter int unsigned      WIDTH     = 8,
   parameter int unsigned      DEPTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{DEFAULT_RESET_BIT}}
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable,
   input  logic                        flush,
   input  logic [WIDTH-1:0]            data_in,
   input  logic                        valid_in,
   input  logic                        err_inject,
   output logic [WIDTH-1:0]            data_out,
   output logic                        valid_out,
   output logic [DEPTH*WIDTH-1:0]      taps,
   output logic [occ_width(DEPTH)-1:0] occupancy,
   output logic                        parity_err
);

   localparam int unsigned REC_W = rec_width(WIDTH);
   localparam int unsigned OCC_W = occ_width(DEPTH);
   localparam int unsigned V_BIT = WIDTH + REC_VALID_OFS;
   localparam int unsigned P_BIT = WIDTH + REC_PARITY_OFS;

   logic [REC_W-1:0] rec [DEPTH];
   logic             parity_in;

`ifdef CE_DELAY_PARITY_EN
   assign parity_in = (^data_in) ^ err_inject;
`else
   logic unused_err_inject;
   logic unused_last_parity;
   assign unused_err_inject  = err_inject;
   assign unused_last_parity = rec[DEPTH-1][P_BIT];
   assign parity_in          = 1'b0;
`endif

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      if (k == 0) begin : g_head
         ce_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .enable_i (enable),
            .flush_i  (flush),
            .data_i   (data_in),
            .valid_i  (valid_in),
            .parity_i (parity_in),
            .rec_o    (rec[k])
         );
      end else begin : g_body
         ce_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_stage (
            .clk_i    (clk),
            .rst_ni   (rst_n),
            .enable_i (enable),
            .flush_i  (flush),
            .data_i   (rec[k-1][WIDTH-1:0]),
            .valid_i  (rec[k-1][V_BIT]),
            .parity_i (rec[k-1][P_BIT]),
            .rec_o    (rec[k])
         );
      end
      assign taps[k*WIDTH +: WIDTH] = rec[k][WIDTH-1:0];
   end

   assign data_out  = rec[DEPTH-1][WIDTH-1:0];
   assign valid_out = rec[DEPTH-1][V_BIT];

`ifdef CE_DELAY_PARITY_EN
   assign parity_err = valid_out & ((^data_out) != rec[DEPTH-1][P_BIT]);
`else
   assign parity_err = 1'b0;
`endif

   // Occupancy tracks entries minus exits; simultaneous entry and exit
   // cancel, so the count stays within 0..DEPTH by construction.
   logic [OCC_W-1:0] occ_q, occ_d;

   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (enable) begin
         occ_d = occ_q + OCC_W'(valid_in) - OCC_W'(valid_out);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

endmodule

// File: tb/tb_ce_delay_line.sv
module tb_ce_delay_line;
  localparam int W  = 8;
  localparam int D  = 4;
  localparam int OW = $clog2(D + 1);

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n = 1'b0;
  logic           enable = 1'b0;
  logic           flush = 1'b0;
  logic [W-1:0]   data_in = '0;
  logic           valid_in = 1'b0;
  logic           err_inject = 1'b0;
  logic [W-1:0]   data_out;
  logic           valid_out;
  logic [D*W-1:0] taps;
  logic [OW-1:0]  occupancy;
  logic           parity_err;

  ce_delay_line #(.WIDTH(W), .DEPTH(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .flush      (flush),
    .data_in    (data_in),
    .valid_in   (valid_in),
    .err_inject (err_inject),
    .data_out   (data_out),
    .valid_out  (valid_out),
    .taps       (taps),
    .occupancy  (occupancy),
    .parity_err (parity_err)
  );

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  // behavioural model: the line as an array of words, index 0 newest
  logic [W-1:0] md [D];
  bit           mv [D];
  bit           mc [D];  // word was stored with inverted parity

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_occ();
    int n = 0;
    for (int k = 0; k < D; k++) n += int'(mv[k]);
    return n;
  endfunction

  function automatic logic [D*W-1:0] model_taps();
    logic [D*W-1:0] t;
    for (int k = 0; k < D; k++) t[k*W +: W] = md[k];
    return t;
  endfunction

  function automatic bit model_perr();
`ifdef CE_DELAY_PARITY_EN
    return mv[D-1] & mc[D-1];
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge();
    if (!rst_n || flush) begin
      for (int k = 0; k < D; k++) begin
        md[k] = '0; mv[k] = 1'b0; mc[k] = 1'b0;
      end
    end else if (enable) begin
      for (int k = D - 1; k > 0; k--) begin
        md[k] = md[k-1]; mv[k] = mv[k-1]; mc[k] = mc[k-1];
      end
      md[0] = data_in; mv[0] = valid_in; mc[0] = err_inject;
    end
  endtask

  // driver task: apply inputs for one edge, advance model, land after negedge
  task automatic cycle(input bit r, input bit e, input bit f,
                       input logic [W-1:0] d, input bit v, input bit x);
    rst_n = r; enable = e; flush = f; data_in = d; valid_in = v; err_inject = x;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    #1;
  endtask

  // scoreboard compare process: every cycle once the model is initialised
  always @(negedge clk) begin
    if (check_en) begin
      chk("data_out",   64'(data_out),   64'(md[D-1]));
      chk("valid_out",  64'(valid_out),  64'(mv[D-1]));
      chk("taps",       64'(taps),       64'(model_taps()));
      chk("occupancy",  64'(occupancy),  64'(model_occ()));
      chk("occ_bound",  64'(occupancy <= OW'(D)), 64'd1);
      chk("parity_err", 64'(parity_err), 64'(model_perr()));
    end
  end

  logic [7:0] pw;

  initial begin
    // reset with enable high and all-ones data
    cycle(0, 1, 0, 8'hFF, 1, 0);
    cycle(0, 1, 0, 8'hFF, 1, 0);
    check_en = 1'b1;
    chk("rst_data",  64'(data_out),  64'h00);
    chk("rst_valid", 64'(valid_out), 64'h0);
    chk("rst_occ",   64'(occupancy), 64'h0);

    // streaming 11..44
    for (int i = 1; i <= 4; i++) begin
      pw = 8'(i * 8'h11);
      cycle(1, 1, 0, pw, 1, 0);
      chk("stream_occ", 64'(occupancy), 64'(i));
    end
    chk("stream_first", 64'(data_out),  64'h11);
    chk("stream_vout",  64'(valid_out), 64'h1);

    // stall with changing data_in
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 0, 8'($urandom_range(0, 255)), 1, 1);
      chk("stall_taps", 64'(taps),      64'h11223344);
      chk("stall_occ",  64'(occupancy), 64'h4);
    end
    cycle(1, 1, 0, 8'h55, 1, 0);
    chk("resume_data", 64'(data_out),  64'h22);
    chk("resume_occ",  64'(occupancy), 64'h4);
    cycle(1, 1, 0, 8'h66, 1, 0);
    chk("resume_data2", 64'(data_out), 64'h33);

    // flush together with enable while 3 stages are valid
    cycle(1, 0, 1, 8'h00, 0, 0);
    cycle(1, 1, 0, 8'hA1, 1, 0);
    cycle(1, 1, 0, 8'hA2, 1, 0);
    cycle(1, 1, 0, 8'hA3, 1, 0);
    chk("pre_flush_occ", 64'(occupancy), 64'h3);
    cycle(1, 1, 1, 8'hEE, 1, 0);
    chk("flush_occ",   64'(occupancy), 64'h0);
    chk("flush_taps",  64'(taps),      64'h0);
    chk("flush_vout",  64'(valid_out), 64'h0);

    // mixed valid 1,0,1,1
    cycle(1, 1, 0, 8'hB1, 1, 0); chk("mix_occ1", 64'(occupancy), 64'h1);
    cycle(1, 1, 0, 8'hB2, 0, 0); chk("mix_occ2", 64'(occupancy), 64'h1);
    cycle(1, 1, 0, 8'hB3, 1, 0); chk("mix_occ3", 64'(occupancy), 64'h2);
    cycle(1, 1, 0, 8'hB4, 1, 0); chk("mix_occ4", 64'(occupancy), 64'h3);
    chk("mix_vout1", 64'(valid_out), 64'h1);
    cycle(1, 1, 0, 8'h00, 0, 0); chk("mix_vout2", 64'(valid_out), 64'h0);
    cycle(1, 1, 0, 8'h00, 0, 0); chk("mix_vout3", 64'(valid_out), 64'h1);
    cycle(1, 1, 0, 8'h00, 0, 0); chk("mix_vout4", 64'(valid_out), 64'h1);
    chk("mix_data4", 64'(data_out), 64'hB4);

    // parity error injection on 8'h5A
    cycle(1, 0, 1, 8'h00, 0, 0);
    cycle(1, 1, 0, 8'h5A, 1, 1);
    chk("par_pre1", 64'(parity_err), 64'h0);
    cycle(1, 1, 0, 8'h3C, 1, 0); chk("par_pre2", 64'(parity_err), 64'h0);
    cycle(1, 1, 0, 8'h0F, 1, 0); chk("par_pre3", 64'(parity_err), 64'h0);
    cycle(1, 1, 0, 8'h81, 1, 0);
    chk("par_word", 64'(data_out), 64'h5A);
`ifdef CE_DELAY_PARITY_EN
    chk("par_hit", 64'(parity_err), 64'h1);
`else
    chk("par_off", 64'(parity_err), 64'h0);
`endif
    cycle(1, 1, 0, 8'h42, 1, 0);
    chk("par_post", 64'(parity_err), 64'h0);

    // randomized traffic against the model
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 49) != 0,
            $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0,
            8'($urandom_range(0, 255)),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0);
    end

    check_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ce_delay_line.md
# ce_delay_line

Parametrised clock-enabled delay line: DEPTH cascaded WIDTH-bit flip-flop stages, each with its own valid bit. All stages advance together on a shared enable. Adds a flush control, a live occupancy count and optional per-stage parity. It is the successor to the single-bit enable flip-flop and is used for aligning datapath operands and control across stallable CPU pipeline stages.

## Interface
- WIDTH, 8, data bits per stage (≥1)
- DEPTH, 4, number of stages = latency in enabled cycles (≥1)
- RESET_VAL, {WIDTH{1'b0}}, value loaded into every data stage on reset and flush
- clk  in  1  rising-edge clock, the only clock
- rst_n  in  1  reset: one clock; reset is synchronous and active-low
- enable  in  1  1 = shift all stages one place; 0 = hold every register
- flush  in  1  1 = invalidate all stages on next edge
- data_in  in  WIDTH  data entering stage 0
- valid_in  in  1  qualifier for data_in
- err_inject  in  1  invert stored parity of the incoming word (used only with the macro)
- data_out  out  WIDTH  data of stage DEPTH-1
- valid_out  out  1  valid bit of stage DEPTH-1
- taps  out  DEPTH*WIDTH  all stage data; stage k occupies bits [k*WIDTH +: WIDTH]
- occupancy  out  $clog2(DEPTH+1)  number of stages with valid=1
- parity_err  out  1  parity mismatch on the output stage

## Operation
- Priority at each rising edge: rst_n=0 > flush=1 > enable=1 > hold.
- Reset (rst_n=0): every data stage = RESET_VAL, every valid = 0, occupancy = 0, parity bits = ^RESET_VAL. As a result, data_out = RESET_VAL, valid_out = 0, parity_err = 0.
- Flush: identical to reset and independent of enable. The word on data_in in that cycle is discarded.
- Shift (enable=1, flush=0): stage0 ← {data_in, valid_in}; stage k ← stage k-1 for k = 1..DEPTH-1. The last stage's content is dropped.
- Hold (enable=0): every register, including occupancy, keeps its value. data_in and valid_in are ignored.
- Invalid words still shift. Data moves regardless of valid; valid only qualifies it.
- Occupancy on a shift: occupancy + valid_in − valid_out(pre-edge).
  - Simultaneous entry and exit leaves the count unchanged.
  - The count never exceeds DEPTH and never underflows. The bench asserts this every cycle.
- DEPTH=1: a single enable flip-flop with valid; occupancy is 1 bit.
- rst_n deasserted mid-stream: the pipeline restarts empty. No partial words survive.

## Timing
- Latency: a word presented with enable=1 at edge n appears on data_out after DEPTH enabled edges. With enable held high, that is edge n+DEPTH−1 (visible in the following cycle).
- Stalls extend latency one cycle per enable=0 cycle. No words are lost or duplicated.
- Every output comes directly from a register. parity_err is a single XOR-reduce plus compare on registered last-stage bits, with no input-to-output combinational path.
- Throughput: one word per enabled cycle, with no bubbles inserted.

## Configuration
- CE_DELAY_PARITY_EN defined:
  - Each stage carries an extra parity bit. Stage 0 captures ^data_in XOR err_inject, and the bit shifts with its data.
  - parity_err = valid_out & (^data_out != parity_last).
- CE_DELAY_PARITY_EN undefined:
  - No parity storage is built.
  - parity_err is tied to 0 and err_inject is ignored.
  - The port list is identical in both builds.

## Structure
- Package ce_delay_pkg holds:
  - the occupancy width function (clog2 of DEPTH+1);
  - the stage record layout {parity, valid, data};
  - the default RESET_VAL.
- Sub-module ce_stage: one WIDTH-bit enable/flush stage with valid and optional parity, instantiated DEPTH times by a generate loop.
- The top level holds only the occupancy counter and output assignment.

## Test plan
- Reset: drive rst_n=0 for 2 cycles with enable=1 and data_in=8'hFF → data_out=8'h00, valid_out=0, occupancy=0.
- Streaming: hold enable=1 and send 8'h11, 22, 33, 44, 55 with valid → 8'h11 appears on data_out 4 edges after entry, followed by the rest in order. Occupancy rises 1, 2, 3, 4 and stays at 4.
- Stall: with 8'h11..44 loaded, hold enable=0 for 3 cycles while data_in changes → taps unchanged and occupancy stays at 4. Resume → 8'h11 exits on the first enabled edge.
- Flush versus enable: set flush=1 together with enable=1 while 3 stages are valid → the next cycle shows all valid bits 0, occupancy=0 and all taps = RESET_VAL.
- Mixed valid: apply valid_in pattern 1, 0, 1, 1 → occupancy follows 1, 1, 2, 3. valid_out reproduces the pattern delayed by 4 cycles.
- Parity (macro on): inject err_inject=1 on word 8'h5A → parity_err=1 exactly in the cycle that word is on data_out, and 0 at all other times. With the macro off, parity_err stays 0 throughout.
